// File: rtl/led_breath_pwm.sv
// led_breath_pwm: PWM dimmer for a 4-LED water-lamp pattern with a triangular breathing ramp or steady full brightness.
// Pattern, mode and brightness only change at PWM frame boundaries so each frame is glitch-free.
module led_breath_pwm #(
    parameter logic [7:0] PWM_CNT_MAX     = 8'd15,
    parameter logic [7:0] FRAMES_PER_STEP = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] led_state_in,
    input  logic       mode_breath,
    output logic [3:0] n_led_out,
    output logic       frame_done,
    output logic [7:0] duty
);
    typedef enum logic [1:0] {RISE, FALL, HOLD} state_t;
    localparam logic [7:0] DUTY_MAX = PWM_CNT_MAX + 8'd1;
    state_t     state, state_next;
    logic [7:0] pwm_cnt, frame_cnt, duty_next;
    logic [3:0] pattern_q;
    logic       frame_end, step_tick;
    assign frame_end = pwm_cnt == PWM_CNT_MAX;
    assign step_tick = frame_end && frame_cnt == FRAMES_PER_STEP - 8'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt    <= 8'd0;
            frame_cnt  <= 8'd0;
            pattern_q  <= 4'b0000;
            n_led_out  <= 4'b1111;
            frame_done <= 1'b0;
        end else begin
            pwm_cnt    <= frame_end ? 8'd0 : pwm_cnt + 8'd1;
            frame_cnt  <= step_tick ? 8'd0 : frame_end ? frame_cnt + 8'd1 : frame_cnt;
            pattern_q  <= frame_end ? led_state_in : pattern_q;
            n_led_out  <= ~(pattern_q & {4{pwm_cnt < duty}});
            frame_done <= frame_end;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RISE;
            duty  <= 8'd0;
        end else begin
            state <= state_next;
            duty  <= duty_next;
        end
    end
    // Steady mode wins over the ramp; leaving HOLD keeps full brightness until the next step.
    always_comb begin
        state_next = state;
        duty_next  = duty;
        if (frame_end && !mode_breath) begin
            state_next = HOLD;
            duty_next  = DUTY_MAX;
        end else if (frame_end && state == HOLD) begin
            state_next = FALL;
        end else if (step_tick && state == RISE && duty != DUTY_MAX) begin
            duty_next  = duty + 8'd1;
            state_next = (duty_next == DUTY_MAX) ? FALL : RISE;
        end else if (step_tick && state == FALL && duty != 8'd0) begin
            duty_next  = duty - 8'd1;
            state_next = (duty_next == 8'd0) ? RISE : FALL;
        end
    end
endmodule

// File: tb/tb_led_breath_pwm.sv
// tb_led_breath_pwm: directed checks of the breathing PWM with default and fast (3/1) parameter sets.
module tb_led_breath_pwm;
  logic       clk = 1'b0, rst = 1'b1, mode_breath = 1'b1;
  logic [3:0] led_state_in = 4'b0001;
  logic [3:0] n1, n2;
  logic       fd1, fd2;
  logic [7:0] d1, d2;
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;
  led_breath_pwm dut1 (.clk(clk), .rst(rst), .led_state_in(led_state_in), .mode_breath(mode_breath),
                       .n_led_out(n1), .frame_done(fd1), .duty(d1));
  led_breath_pwm #(.PWM_CNT_MAX(8'd3), .FRAMES_PER_STEP(8'd1)) dut2 (.clk(clk), .rst(rst),
                       .led_state_in(led_state_in), .mode_breath(mode_breath),
                       .n_led_out(n2), .frame_done(fd2), .duty(d2));
  function automatic int tri_wave(input int s, input int top);
    int d = s % (2 * top);
    return d <= top ? d : 2 * top - d;
  endfunction
  function automatic int duty1(input int k); return tri_wave(k / 32, 16); endfunction
  function automatic int duty2(input int k); return tri_wave(k / 4, 4); endfunction
  function automatic logic [3:0] nled1(input int k);
    return (k >= 17 && ((k - 1) % 16) < duty1(k - 1)) ? 4'b1110 : 4'b1111;
  endfunction
  function automatic logic [3:0] nled2(input int k);
    return (k >= 5 && ((k - 1) % 4) < duty2(k - 1)) ? 4'b1110 : 4'b1111;
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  initial begin
    tick(3);
    chk("rst_n1", n1, 4'b1111);
    chk("rst_d1", d1, 8'd0);
    chk("rst_fd1", fd1, 1'b0);
    chk("rst_n2", n2, 4'b1111);
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 1100; k++) begin
      tick(1);
      chk("brth_d1", d1, 8'(duty1(cyc)));
      chk("brth_fd1", fd1, 1'(cyc % 16 == 0));
      chk("brth_n1", n1, nled1(cyc));
      chk("brth_d2", d2, 8'(duty2(cyc)));
      chk("brth_fd2", fd2, 1'(cyc % 4 == 0));
      chk("brth_n2", n2, nled2(cyc));
    end
    mode_breath  = 1'b0;
    led_state_in = 4'b1010;
    tick(3);
    chk("hold_pre_d1", d1, 8'd2);
    tick(1);
    chk("hold_d1", d1, 8'd16);
    chk("hold_d2", d2, 8'd4);
    for (int k = 0; k < 32; k++) begin
      tick(1);
      chk("hold_n1", n1, 4'b0101);
      chk("hold_n2", n2, 4'b0101);
      chk("hold_d1b", d1, 8'd16);
    end
    mode_breath  = 1'b1;
    led_state_in = 4'b0001;
    tick(16);
    chk("fall_d1_a", d1, 8'd16);
    tick(31);
    chk("fall_d1_b", d1, 8'd16);
    tick(1);
    chk("fall_d1_c", d1, 8'd15);
    tick(5);
    led_state_in = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("pat_old_n1", n1, 4'b1110);
    end
    tick(1);
    chk("pat_end_n1", n1, 4'b1111);
    tick(1);
    chk("pat_new_n1", n1, 4'b1101);
    tick(1383 - cyc);
    chk("pre_rst_d1", d1, 8'd9);
    chk("pre_rst_n1", n1, 4'b1101);
    rst = 1'b1;
    #1;
    chk("arst_n1", n1, 4'b1111);
    chk("arst_d1", d1, 8'd0);
    chk("arst_fd1", fd1, 1'b0);
    tick(1);
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      chk("post_fd1", fd1, 1'(k == 16));
      chk("post_d1", d1, 8'd0);
      chk("post_n1", n1, 4'b1111);
      chk("post_fd2", fd2, 1'(k % 4 == 0));
      chk("post_d2", d2, 8'(duty2(k)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_breath_pwm.md
LED_BREATH_PWM -- requirements
Module: led_breath_pwm

Interface
REQ-001 SHALL have parameter PWM_CNT_MAX, default 8'd15, last count of the PWM frame; frame = PWM_CNT_MAX+1 cycles; legal range 1..254.
REQ-002 SHALL have parameter FRAMES_PER_STEP, default 8'd2, PWM frames per brightness step; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port led_state_in, input, 4, active-high lamp pattern from the water-lamp stage (bit i = LED i lit).
REQ-006 SHALL have port mode_breath, input, 1; 1 = breathing fade, 0 = steady full brightness.
REQ-007 SHALL have port n_led_out, output, 4, active-low LED drive (0 = LED on), registered.
REQ-008 SHALL have port frame_done, output, 1, one-cycle pulse per completed PWM frame, registered.
REQ-009 SHALL have port duty, output, 8, current brightness level 0..PWM_CNT_MAX+1, registered.

Function
REQ-010 SHALL count pwm_cnt 0..PWM_CNT_MAX, +1 per cycle, wrapping to 0 after PWM_CNT_MAX; frame_end = (pwm_cnt == PWM_CNT_MAX).
REQ-011 SHALL count frame_cnt 0..FRAMES_PER_STEP-1, advancing only on frame_end, wrapping to 0; step_tick = frame_end && frame_cnt == FRAMES_PER_STEP-1.
REQ-012 SHALL latch led_state_in into pattern_q only on frame_end; mid-frame input changes have no effect until the next frame.
REQ-013 SHALL sample mode_breath only on frame_end; mode changes take effect at the first frame boundary.
REQ-014 SHALL implement FSM states RISE, FALL, HOLD.
REQ-015 RISE: on step_tick duty += 1; when the incremented duty equals PWM_CNT_MAX+1, next state FALL.
REQ-016 FALL: on step_tick duty -= 1; when the decremented duty equals 0, next state RISE.
REQ-017 Any state, frame_end with sampled mode_breath=0: next state HOLD, duty = PWM_CNT_MAX+1; this has priority over the step update.
REQ-018 HOLD, frame_end with sampled mode_breath=1: next state FALL, duty stays PWM_CNT_MAX+1; first decrement at the next step_tick.
REQ-019 duty SHALL never leave 0..PWM_CNT_MAX+1; no wrap-around or underflow.
REQ-020 LED i on-condition = pattern_q[i] && (pwm_cnt < duty); n_led_out[i] SHALL be the registered inverse, one cycle latency.
REQ-021 duty=0 SHALL give all LEDs off for the whole frame; duty=PWM_CNT_MAX+1 SHALL give selected LEDs on for the whole frame.
REQ-022 frame_done SHALL be 1 for exactly the cycle after frame_end, else 0.
REQ-023 On step_tick coinciding with frame_end (always), pattern latch, mode sample and duty update SHALL occur in the same cycle.

Reset
REQ-024 While rst=1: pwm_cnt=0, frame_cnt=0, duty=0, state=RISE, pattern_q=4'b0000, n_led_out=4'b1111, frame_done=0, asynchronously.
REQ-025 Reset asserted mid-frame or mid-ramp SHALL abort immediately; after release counting restarts from pwm_cnt=0 in RISE with no carried state.

Verification
REQ-026 Defaults, rst released, mode_breath=1, led_state_in=4'b0001 -> n_led_out=4'b1111 for frames 0-1; duty=1 from cycle 32; from cycle 33 n_led_out=4'b1110 for exactly 1 cycle per 16-cycle frame.
REQ-027 Breathing run of 32 steps -> duty rises 0..16, state to FALL at duty=16, falls to 0, back to RISE; duty never 17 or 255.
REQ-028 mode_breath=0 mid-frame with led_state_in=4'b1010 -> at next frame boundary duty=16, then n_led_out=4'b0101 constantly.
REQ-029 led_state_in changes 4'b0001->4'b0010 at pwm_cnt=5 -> n_led_out keeps bit 0 pattern until frame end, bit 1 pattern from next frame.
REQ-030 rst pulsed at pwm_cnt=7, duty=9 -> same cycle n_led_out=4'b1111, duty=0, frame_done=0; first frame_done 16 cycles after release.
REQ-031 Every frame: exactly one frame_done pulse, spacing 16 cycles (PWM_CNT_MAX=15); repeat with PWM_CNT_MAX=3, FRAMES_PER_STEP=1 -> spacing 4, duty step every 4 cycles.
